// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: clk_out toggles every div_cur cycles of clk_in, with a
// glitch-free divisor handshake and a clean stop. CLK_DIV_CTRL_TOGGLE_CNT_EN adds toggle_cnt.
module clk_div_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_RESET = 10000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_data,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             div_err
`ifdef CLK_DIV_CTRL_TOGGLE_CNT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             xfer, div_zero, terminal;

    assign div_ready = ~pend_q;
    assign xfer      = div_valid & div_ready;
    assign div_zero  = (div_data == '0);
    assign terminal  = (count_q == div_cur_q - WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        err_d      = err_q;

        // A zero divisor completes the handshake but only raises the error flag.
        if (xfer) begin
            err_d = div_zero;
        end

        unique case (state_q)
            StIdle: begin
                count_d   = '0;
                clk_out_d = 1'b0;
                if (xfer && !div_zero) begin
                    div_cur_d = div_data;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun, StHalt: begin
                if (terminal) begin
                    count_d   = '0;
                    clk_out_d = ~clk_out_q;
                    tick_d    = 1'b1;
                    if (pend_q) begin
                        div_cur_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
                // pend_q is still 0 here, so a divisor taken on a terminal waits one half-period.
                if (xfer && !div_zero) begin
                    div_pend_d = div_data;
                    pend_d     = 1'b1;
                end
                if (state_q == StRun) begin
                    if (!en) begin
                        state_d = StHalt;
                    end
                end else if (en) begin
                    state_d = StRun;
                end else if (terminal && clk_out_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            div_cur_q  <= WIDTH'(DIV_RESET);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = (state_q != StIdle);
    assign div_err = err_q;

`ifdef CLK_DIV_CTRL_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt_q <= '0;
        end else if (tick_d) begin
            toggle_cnt_q <= toggle_cnt_q + 16'd1;
        end
    end

    assign toggle_cnt = toggle_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the divider.
module tb_clk_div_ctrl;

    logic        clk_in;
    logic        rst_n;
    logic        en;
    logic        div_valid;
    logic [31:0] div_data;
    logic        div_ready;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic        div_err;
`ifdef CLK_DIV_CTRL_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
`endif

    clk_div_ctrl #(
        .WIDTH     (32),
        .DIV_RESET (10000)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_valid (div_valid),
        .div_data  (div_data),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .div_err   (div_err)
`ifdef CLK_DIV_CTRL_TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a half-period length, a position within it and a stop request.
    bit          m_busy, m_halt, m_lvl, m_tick, m_err, m_has_next;
    int unsigned m_cnt, m_half, m_next, m_tc;

    task automatic model_reset();
        m_busy = 0; m_halt = 0; m_lvl = 0; m_tick = 0; m_err = 0; m_has_next = 0;
        m_cnt = 0; m_half = 10000; m_next = 0; m_tc = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int unsigned d);
        bit acc;
        bit end_half;
        acc = v && !m_has_next;
        if (!m_busy) begin
            m_tick = 0;
            m_cnt  = 0;
            m_lvl  = 0;
            if (acc && d != 0) m_half = d;
            if (e) begin
                m_busy = 1;
                m_halt = 0;
            end
        end else begin
            end_half = (m_cnt + 1 == m_half);
            if (end_half) begin
                m_cnt  = 0;
                m_lvl  = !m_lvl;
                m_tick = 1;
                m_tc   = (m_tc + 1) % 65536;
                if (m_has_next) begin
                    m_half     = m_next;
                    m_has_next = 0;
                end
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 0;
            end
            if (acc && d != 0) begin
                m_next     = d;
                m_has_next = 1;
            end
            if (e) m_halt = 0;
            else if (!m_halt) m_halt = 1;
            else if (end_half && !m_lvl) begin
                m_busy = 0;
                m_halt = 0;
            end
        end
        if (acc) m_err = (d == 0);
    endtask

    // One clock: called and returning at posedge+1.
    task automatic cyc(input bit e, input bit v, input int unsigned d);
        en        = e;
        div_valid = v;
        div_data  = d;
        #1;
        check("div_ready", div_ready, !m_has_next);
        @(posedge clk_in);
        model_step(e, v, d);
        #1;
        check("clk_out", clk_out, m_lvl);
        check("tick", tick, m_tick);
        check("busy", busy, m_busy);
        check("div_err", div_err, m_err);
`ifdef CLK_DIV_CTRL_TOGGLE_CNT_EN
        check("toggle_cnt", toggle_cnt, m_tc);
`endif
    endtask

    // Asynchronous reset pulse in the middle of a clock period.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_clk_out", clk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", div_ready, 1);
        check("rst_err", div_err, 0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    int rises[$];
    int falls[$];
    int ticks[$];
    bit prev_clk;
    bit en_r;

    initial begin
        rst_n = 1'b1; en = 0; div_valid = 0; div_data = 0;
        model_reset();
        @(posedge clk_in);
        #1;
        do_reset();

        // Reset divisor: first rise exactly 10000 cycles after RUN entry.
        cyc(1, 0, 0);
        for (int k = 1; k <= 10000; k++) cyc(1, 0, 0);
        check("div_reset_first_rise", clk_out, 1);

        // Divisor 3: rises at 3, 9, 15 and falls at 6, 12 after RUN entry.
        do_reset();
        cyc(0, 1, 3);
        cyc(1, 0, 0);
        prev_clk = clk_out;
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 0, 0);
            if (clk_out && !prev_clk) rises.push_back(k);
            if (!clk_out && prev_clk) falls.push_back(k);
            if (tick) ticks.push_back(k);
            prev_clk = clk_out;
        end
        check("n_rises", rises.size(), 3);
        check("n_falls", falls.size(), 2);
        check("n_ticks", ticks.size(), 5);
        if (rises.size() == 3) begin
            check("rise0", rises[0], 3);
            check("rise1", rises[1], 9);
            check("rise2", rises[2], 15);
        end
        if (falls.size() == 2) begin
            check("fall0", falls[0], 6);
            check("fall1", falls[1], 12);
        end
        if (ticks.size() == 5) begin
            for (int i = 0; i < 5; i++) check("tick_pos", ticks[i], 3 * (i + 1));
        end

        // Divisor 4 running, 2 offered mid half-period.
        do_reset();
        cyc(0, 1, 4);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 2);
        check("ready_drop", div_ready, 0);
        for (int k = 0; k < 16; k++) cyc(1, 0, 0);
        check("ready_back", div_ready, 1);

        // Zero divisor in RUN, then 5.
        cyc(1, 1, 0);
        check("err_set", div_err, 1);
        for (int k = 0; k < 6; k++) cyc(1, 0, 0);
        cyc(1, 1, 5);
        check("err_clear", div_err, 0);
        for (int k = 0; k < 12; k++) cyc(1, 0, 0);

        // Stop with divisor 3, from both clock levels.
        do_reset();
        cyc(0, 1, 3);
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0);
        check("stop_hi_idle", busy, 0);
        cyc(1, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0);
        check("stop_lo_idle", busy, 0);

        // Randomized traffic with occasional mid-period resets.
        do_reset();
        cyc(0, 1, $urandom_range(1, 5));
        en_r = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) en_r = !en_r;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                cyc(0, 1, $urandom_range(1, 5));
            end else begin
                cyc(en_r, ($urandom_range(0, 5) == 0), $urandom_range(0, 5));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
